rng_chaos_ctrl: RTL

Sequencer and harvester for the piecewise chaos generator `rng_chaos`.
- Owns the generator's active-low reset, so it decides when the core is frozen at its initial state and when it runs.
- After a configurable warm-up it samples one bit per decimation period from x/y/z, packs 32 bits into a word and buffers words in a small FIFO.
- Consumers drain the FIFO through a read-enable port, which is wired to the WB/LA glue in `user_proj_example`.

---
 rtl/rng_ctrl_pkg.sv | 16 +
 rtl/rng_word_fifo.sv | 57 +++++
 rtl/rng_chaos_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rng_ctrl_pkg.sv
// Shared state encodings and constants for the rng_chaos sequencer/harvester.
package rng_ctrl_pkg;

    localparam int unsigned WORD_W = 32;

    // Value the core holds on y while its reset is asserted.
    localparam logic [WORD_W-1:0] CORE_Y_INIT = 32'h0040_0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARMUP  = 3'd1,
        HARVEST = 3'd2,
        FULL    = 3'd3
    } ctrl_state_e;

endpackage

// File: rtl/rng_word_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module rng_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push, do_pop;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign level    = level_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/rng_chaos_ctrl.sv
// Sequencer/harvester for rng_chaos: owns the core reset, packs decimated bits into words.
// Define RNG_CTRL_HEALTH_EN to enable the repeated-word health test.
module rng_chaos_ctrl
    import rng_ctrl_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = 256,
    parameter int unsigned DECIM         = 4,
    parameter int unsigned BIT_SEL       = 8,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned REP_LIMIT     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic [31:0]                 x,
    input  logic [31:0]                 y,
    input  logic [31:0]                 z,
    output logic                        core_rst_n,
    input  logic                        rd_en,
    output logic [31:0]                 rd_data,
    output logic                        rd_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [2:0]                  state_o,
    output logic                        health_fail
);

    localparam int unsigned WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST  = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [7:0]        DECIM_LAST = 8'(DECIM - 1);

    if (DECIM < 1 || DECIM > 255 || BIT_SEL > 31 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REP_LIMIT < 1) begin : g_param_check
        $error("rng_chaos_ctrl: parameter out of range");
    end

    ctrl_state_e       state_q, state_d;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [7:0]        decim_cnt_q, decim_cnt_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] word_q, word_d, hold_q, hold_d, word_next, push_data;
    logic              sample_bit, word_done, health_trip, start_ok;
    logic              push, can_push, fifo_full, fifo_empty;

    assign sample_bit = x[BIT_SEL] ^ y[BIT_SEL] ^ z[BIT_SEL];
    assign word_next  = {word_q[WORD_W-2:0], sample_bit};
    assign word_done  = (state_q == HARVEST) && (decim_cnt_q == DECIM_LAST) &&
                        (bit_cnt_q == 5'd31) && !stop;
    // A pop in the same cycle frees the slot the push needs.
    assign can_push   = !fifo_full || (rd_en && !fifo_empty);

`ifdef RNG_CTRL_HEALTH_EN
    logic [WORD_W-1:0] prev_word_q;
    logic              prev_valid_q, health_fail_q;
    logic [31:0]       rep_cnt_q, rep_cnt_next;

    assign rep_cnt_next = (prev_valid_q && (word_next == prev_word_q)) ?
                          rep_cnt_q + 32'd1 : 32'd1;
    assign health_trip  = word_done && (rep_cnt_next >= 32'(REP_LIMIT));
    assign start_ok     = !health_fail_q;
    assign health_fail  = health_fail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_word_q   <= '0;
            prev_valid_q  <= 1'b0;
            rep_cnt_q     <= '0;
            health_fail_q <= 1'b0;
        end else if (word_done) begin
            prev_word_q  <= word_next;
            prev_valid_q <= 1'b1;
            rep_cnt_q    <= rep_cnt_next;
            if (health_trip) begin
                health_fail_q <= 1'b1;
            end
        end
    end
`else
    assign health_trip = 1'b0;
    assign start_ok    = 1'b1;
    assign health_fail = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        decim_cnt_d = decim_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        word_d      = word_q;
        hold_d      = hold_q;
        push        = 1'b0;
        push_data   = word_next;

        unique case (state_q)
            IDLE: begin
                if (start && !stop && start_ok) begin
                    state_d    = WARMUP;
                    warm_cnt_d = '0;
                end
            end
            WARMUP: begin
                if (warm_cnt_q == WARM_LAST) begin
                    state_d     = HARVEST;
                    warm_cnt_d  = '0;
                    decim_cnt_d = '0;
                    bit_cnt_d   = '0;
                    word_d      = '0;
                end else begin
                    warm_cnt_d = warm_cnt_q + WARM_W'(1);
                end
            end
            HARVEST: begin
                if (decim_cnt_q == DECIM_LAST) begin
                    decim_cnt_d = '0;
                    bit_cnt_d   = bit_cnt_q + 5'd1;
                    word_d      = word_next;
                    if (bit_cnt_q == 5'd31) begin
                        bit_cnt_d = '0;
                        word_d    = '0;
                        if (health_trip) begin
                            state_d = IDLE;
                        end else if (can_push) begin
                            push = 1'b1;
                        end else begin
                            hold_d  = word_next;
                            state_d = FULL;
                        end
                    end
                end else begin
                    decim_cnt_d = decim_cnt_q + 8'd1;
                end
            end
            FULL: begin
                if (can_push) begin
                    push        = 1'b1;
                    push_data   = hold_q;
                    state_d     = HARVEST;
                    decim_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // stop overrides everything; queued FIFO words survive it.
        if (stop && (state_q != IDLE)) begin
            state_d     = IDLE;
            push        = 1'b0;
            warm_cnt_d  = '0;
            decim_cnt_d = '0;
            bit_cnt_d   = '0;
            word_d      = '0;
            hold_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            warm_cnt_q  <= '0;
            decim_cnt_q <= '0;
            bit_cnt_q   <= '0;
            word_q      <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            decim_cnt_q <= decim_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            word_q      <= word_d;
            hold_q      <= hold_d;
        end
    end

    rng_word_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(WORD_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .pop      (rd_en),
        .pop_data (rd_data),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rd_valid   = !fifo_empty;
    assign core_rst_n = (state_q != IDLE);
    assign state_o    = state_q;

endmodule
